rr_req_arbiter8: RTL and testbench
==================================

Name: rr_req_arbiter8

Overview:
- Round-robin request arbiter that sits directly upstream of the 8-to-3 encoder stage.
- Captures sticky request pulses from N sources and issues exactly one registered one-hot grant at a time, using a valid/ready handshake.
- Also presents the binary index of each grant, so the downstream encoder output can be cross-checked against it.
- Guarantees one-hot input to the encoder: never zero-hot while valid, never multi-hot.

Parameters:
- N, 8, number of requesters; power of two, 2..16.
- IDXW, $clog2(N) (3 at default), width of the grant index; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req_i  input  N  request pulses or levels; bit k high in a cycle sets pending[k].
- gnt_o  output  N  registered one-hot grant; all-zero when gnt_valid_o=0.
- gnt_idx_o  output  IDXW  binary index of the set bit in gnt_o; 0 when not valid.
- gnt_valid_o  output  1  grant present.
- gnt_ready_i  input  1  downstream accepts the grant this cycle.
- pending_o  output  N  current pending register, for debug and verification.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst). All state updates on rising clk.
- Reset values: pending=0, gnt_o=0, gnt_idx_o=0, gnt_valid_o=0, ptr=N-1. With ptr=N-1, index 0 wins first.
  - rst mid-handshake drops the grant and all pending requests; nothing is replayed.
- Pending register, per bit k:
  - next = (pending[k] & ~clr[k]) | req_i[k].
  - clr[k] = gnt_valid_o & gnt_ready_i & gnt_o[k].
  - Set wins over clear in the same cycle: the accepted requester stays pending and is re-granted later in round-robin order.
  - A pulse on an already-pending bit is absorbed, not counted.
- Output register has two states, EMPTY (gnt_valid_o=0) and HOLD (gnt_valid_o=1).
  - EMPTY: if avail != 0, load a grant and go to HOLD. avail = pending & ~clr; req_i from this same cycle is not yet visible.
  - HOLD with gnt_ready_i=0: gnt_o and gnt_idx_o are stable and must not change (stall).
  - HOLD with gnt_ready_i=1: if avail != 0, load the next grant and stay in HOLD (back-to-back, one grant per clock). Otherwise go to EMPTY.
- Selection:
  - Search the indices ptr+1, ptr+2, … modulo N; the first set bit of avail wins.
  - On every load, ptr becomes the loaded index. gnt_o = 1<<idx, gnt_idx_o = idx.
- Latency: req_i[k] high in cycle t, with the arbiter idle and nothing else pending, gives gnt_valid_o=1 with gnt_o[k]=1 in cycle t+2.
- Fairness: with all N bits continuously pending and gnt_ready_i=1, grants rotate 0,1,…,N-1,0. No requester waits more than N accepted grants.
- Wrap-around: with ptr=N-1, the search continues at 0. If the only avail bit is ptr itself, it is still granted.
- gnt_ready_i while gnt_valid_o=0 is ignored.

Optional Feature:
- Macro: RR_ARB_OVERFLOW_EN.
- Defined: adds output ovf_o (1 bit, reset 0).
  - ovf_o is a registered one-cycle pulse, asserted when any req_i[k]=1 arrives while pending[k]=1 and clr[k]=0, i.e. a lost duplicate request.
  - Adds output ovf_idx_o (IDXW bits). On a pulse it holds the lowest such k; it keeps its value between pulses.
- Undefined: neither port exists; duplicates are silently absorbed; all other behaviour is identical.

Decomposition:
- Shared package rr_arb_pkg:
  - localparam ARB_N=8 and ARB_IDXW=3.
  - typedef for the request vector.
  - typedef enum for output state {EMPTY, HOLD}.
  - function onehot2idx, used by the arbiter and by the encoder bench model.
- One sub-module: rr_pick. Purely combinational; takes avail and ptr and returns the one-hot winner and its index, using a double-width rotate-and-priority scheme.

Test Plan:
- Single request: after reset, req_i=8'h04 for 1 cycle, ready=1 → cycle t+2: gnt_o=8'h04, gnt_idx_o=2, valid=1. Next cycle: valid=0, pending=0.
- All pending: req_i=8'hFF held, ready=1 → gnt_idx_o sequence 0,1,…,7,0,1 on consecutive cycles; gnt_o always one-hot.
- Stall: pending 8'h81, ready=0 for 5 cycles → gnt_o=8'h01 stable throughout. Then ready=1 → next cycle gnt_o=8'h80, then valid=0.
- Set-beats-clear: grant idx 3 held with ready=1, and req_i[3]=1 in the same cycle → pending[3] stays 1; idx 3 is re-granted after the other pending bits.
- Reset mid-operation: pending=8'hF0, valid=1, rst for 1 cycle → all outputs 0. First grant after the next req_i=8'hF0 is idx 4.
- RR_ARB_OVERFLOW_EN: req_i[5] pulsed twice while pending[5]=1 and not granted → ovf_o pulses for one cycle, ovf_idx_o=5. Without the macro the bench compiles, and the same sequence gives exactly one grant of idx 5.

Source files
------------

// File: rtl/rr_req_arbiter8_pkg.sv
// rr_arb_pkg: shared sizes, request vector type, output-state enum and the one-hot to index helper
package rr_arb_pkg;
  localparam int ARB_N = 8;
  localparam int ARB_IDXW = 3;
  typedef logic [ARB_N-1:0] req_vec_t;
  typedef enum logic {EMPTY, HOLD} state_t;
  function automatic logic [3:0] onehot2idx(input logic [15:0] v);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r |= v[i] ? 4'(i) : 4'd0;
    return r;
  endfunction
endpackage

// File: rtl/rr_req_arbiter8_if.sv
// rr_req_arbiter8_if: request/grant bundle; master = arbiter side, slave = requester/consumer side
// signals: req_i, gnt_o, gnt_idx_o, gnt_valid_o, gnt_ready_i, pending_o (+ ovf_o, ovf_idx_o with RR_ARB_OVERFLOW_EN)
interface rr_req_arbiter8_if #(parameter int N = rr_arb_pkg::ARB_N, localparam int IDXW = $clog2(N));
  logic [N-1:0] req_i;
  logic [N-1:0] gnt_o;
  logic [IDXW-1:0] gnt_idx_o;
  logic gnt_valid_o;
  logic gnt_ready_i;
  logic [N-1:0] pending_o;
`ifdef RR_ARB_OVERFLOW_EN
  logic ovf_o;
  logic [IDXW-1:0] ovf_idx_o;
  modport master(input req_i, gnt_ready_i, output gnt_o, gnt_idx_o, gnt_valid_o, pending_o, ovf_o, ovf_idx_o);
  modport slave(output req_i, gnt_ready_i, input gnt_o, gnt_idx_o, gnt_valid_o, pending_o, ovf_o, ovf_idx_o);
`else
  modport master(input req_i, gnt_ready_i, output gnt_o, gnt_idx_o, gnt_valid_o, pending_o);
  modport slave(output req_i, gnt_ready_i, input gnt_o, gnt_idx_o, gnt_valid_o, pending_o);
`endif
endinterface

// File: rtl/rr_req_arbiter8_pick.sv
// rr_pick: combinational round-robin winner; first set bit of avail searching from ptr+1 modulo N
// ports: avail (candidates), ptr (last granted index) -> gnt (one-hot winner), idx (its index)
module rr_pick import rr_arb_pkg::*; #(parameter int N = ARB_N, localparam int IDXW = $clog2(N)) (
  input logic [N-1:0] avail,
  input logic [IDXW-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [IDXW-1:0] idx
);
  logic [N-1:0] rot, first;
  logic [3:0] off;
  always_comb begin
    // rotate a doubled copy so index ptr+1 lands on bit 0; ptr=N-1 shifts by N and wraps to 0
    rot = N'({avail, avail} >> ((IDXW+1)'(ptr) + (IDXW+1)'(1)));
    first = rot & (~rot + N'(1));
    off = onehot2idx(16'(first));
    idx = IDXW'(4'(ptr) + 4'd1 + off);
    gnt = N'(1) << idx;
  end
endmodule

// File: rtl/rr_req_arbiter8.sv
// rr_req_arbiter8: round-robin arbiter turning sticky request pulses into one registered one-hot grant per handshake
// ports: clk, rst (sync, active-high), bus (rr_req_arbiter8_if.master); RR_ARB_OVERFLOW_EN adds ovf_o/ovf_idx_o
module rr_req_arbiter8 import rr_arb_pkg::*; #(parameter int N = ARB_N, localparam int IDXW = $clog2(N)) (
  input logic clk,
  input logic rst,
  rr_req_arbiter8_if.master bus
);
  state_t state, state_n;
  logic [N-1:0] pending, clr, avail, p_gnt;
  logic [IDXW-1:0] ptr, p_idx;
  logic load;
  rr_pick #(.N(N)) u_pick (.avail(avail), .ptr(ptr), .gnt(p_gnt), .idx(p_idx));
  always_comb begin
    clr = (state == HOLD && bus.gnt_ready_i) ? bus.gnt_o : '0;
    avail = pending & ~clr;
    load = (state == EMPTY || bus.gnt_ready_i) && |avail;
  end
  always_ff @(posedge clk) state <= rst ? EMPTY : state_n;
  always_comb state_n = (state == HOLD && !bus.gnt_ready_i) ? HOLD : (|avail ? HOLD : EMPTY);
  always_comb begin
    bus.gnt_valid_o = state == HOLD;
    bus.pending_o = pending;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      ptr <= IDXW'(N - 1);
      bus.gnt_o <= '0;
      bus.gnt_idx_o <= '0;
    end else begin
      // a new request on the bit being accepted keeps it pending (set beats clear)
      pending <= avail | bus.req_i;
      if (load) begin
        ptr <= p_idx;
        bus.gnt_o <= p_gnt;
        bus.gnt_idx_o <= p_idx;
      end else if (state == HOLD && bus.gnt_ready_i) begin
        bus.gnt_o <= '0;
        bus.gnt_idx_o <= '0;
      end
    end
  end
`ifdef RR_ARB_OVERFLOW_EN
  logic [N-1:0] dup;
  always_comb dup = bus.req_i & avail;
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ovf_o <= 1'b0;
      bus.ovf_idx_o <= '0;
    end else begin
      bus.ovf_o <= |dup;
      if (|dup) bus.ovf_idx_o <= IDXW'(onehot2idx(16'(dup & (~dup + N'(1)))));
    end
  end
`endif
endmodule

// File: tb/tb_rr_req_arbiter8.sv
// tb_rr_req_arbiter8: directed stimulus with a grant-index scoreboard for rr_req_arbiter8
module tb_rr_req_arbiter8;
  import rr_arb_pkg::*;
  logic clk = 0;
  logic rst;
  int checks = 0;
  int fails = 0;
  int q[$];
  int e;
  rr_req_arbiter8_if #(.N(ARB_N)) bus();
  rr_req_arbiter8 dut(.clk(clk), .rst(rst), .bus(bus.master));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic drive(input req_vec_t r);
    bus.req_i = r;
  endtask
  always @(negedge clk) begin
    if (!rst && bus.gnt_valid_o) check("idx_vs_onehot", 32'(bus.gnt_idx_o), 32'(onehot2idx(16'(bus.gnt_o))));
    if (!rst && bus.gnt_valid_o && bus.gnt_ready_i) begin
      if (q.size() == 0) check("unexpected_grant", 32'(bus.gnt_idx_o), 32'hFFFF_FFFF);
      else begin
        e = q.pop_front();
        check("sb_idx", 32'(bus.gnt_idx_o), 32'(e));
        check("sb_gnt", 32'(bus.gnt_o), 32'(1) << e);
      end
    end
  end
  initial begin
    rst = 1;
    drive(8'h00);
    bus.gnt_ready_i = 0;
    step(2);
    check("rst_gnt", 32'(bus.gnt_o), 0);
    check("rst_idx", 32'(bus.gnt_idx_o), 0);
    check("rst_valid", 32'(bus.gnt_valid_o), 0);
    check("rst_pending", 32'(bus.pending_o), 0);
`ifdef RR_ARB_OVERFLOW_EN
    check("rst_ovf", 32'(bus.ovf_o), 0);
`endif
    rst = 0;
    q.push_back(2);
    drive(8'h04);
    bus.gnt_ready_i = 1;
    step(1);
    drive(8'h00);
    check("single_pending", 32'(bus.pending_o), 32'h04);
    check("single_valid_t1", 32'(bus.gnt_valid_o), 0);
    step(1);
    check("single_gnt", 32'(bus.gnt_o), 32'h04);
    check("single_idx", 32'(bus.gnt_idx_o), 2);
    check("single_valid", 32'(bus.gnt_valid_o), 1);
    step(1);
    check("single_done_valid", 32'(bus.gnt_valid_o), 0);
    check("single_done_pending", 32'(bus.pending_o), 0);
    rst = 1;
    step(1);
    rst = 0;
    for (int i = 0; i < 10; i++) q.push_back(i % 8);
    drive(8'hFF);
    step(12);
    rst = 1;
    drive(8'h00);
    step(1);
    rst = 0;
    check("rot_reset_pending", 32'(bus.pending_o), 0);
    check("rot_reset_valid", 32'(bus.gnt_valid_o), 0);
    bus.gnt_ready_i = 0;
    drive(8'h81);
    step(1);
    drive(8'h00);
    step(1);
    q.push_back(0);
    q.push_back(7);
    for (int i = 0; i < 5; i++) begin
      check("stall_gnt", 32'(bus.gnt_o), 32'h01);
      check("stall_valid", 32'(bus.gnt_valid_o), 1);
      step(1);
    end
    bus.gnt_ready_i = 1;
    step(1);
    check("stall_next_gnt", 32'(bus.gnt_o), 32'h80);
    step(1);
    check("stall_done_valid", 32'(bus.gnt_valid_o), 0);
    q.push_back(3);
    q.push_back(4);
    q.push_back(5);
    q.push_back(3);
    drive(8'h38);
    step(1);
    drive(8'h00);
    step(1);
    check("sbc_first_idx", 32'(bus.gnt_idx_o), 3);
    drive(8'h08);
    step(1);
    drive(8'h00);
    check("sbc_pending3", 32'(bus.pending_o[3]), 1);
    step(3);
    check("sbc_done_valid", 32'(bus.gnt_valid_o), 0);
    bus.gnt_ready_i = 0;
    drive(8'hF0);
    step(1);
    drive(8'h00);
    step(1);
    check("mid_valid_before", 32'(bus.gnt_valid_o), 1);
    rst = 1;
    step(1);
    rst = 0;
    check("mid_rst_gnt", 32'(bus.gnt_o), 0);
    check("mid_rst_idx", 32'(bus.gnt_idx_o), 0);
    check("mid_rst_valid", 32'(bus.gnt_valid_o), 0);
    check("mid_rst_pending", 32'(bus.pending_o), 0);
    bus.gnt_ready_i = 1;
    for (int i = 4; i < 8; i++) q.push_back(i);
    drive(8'hF0);
    step(1);
    drive(8'h00);
    step(5);
    check("mid_done_valid", 32'(bus.gnt_valid_o), 0);
    bus.gnt_ready_i = 0;
    drive(8'h21);
    step(1);
    drive(8'h00);
    step(1);
    check("ovf_stall_gnt", 32'(bus.gnt_o), 32'h01);
    drive(8'h20);
    step(1);
    drive(8'h00);
    check("ovf_pending", 32'(bus.pending_o), 32'h21);
`ifdef RR_ARB_OVERFLOW_EN
    check("ovf_pulse", 32'(bus.ovf_o), 1);
    check("ovf_idx", 32'(bus.ovf_idx_o), 5);
`endif
    step(1);
`ifdef RR_ARB_OVERFLOW_EN
    check("ovf_pulse_end", 32'(bus.ovf_o), 0);
    check("ovf_idx_hold", 32'(bus.ovf_idx_o), 5);
`endif
    q.push_back(0);
    q.push_back(5);
    bus.gnt_ready_i = 1;
    step(2);
    check("ovf_done_valid", 32'(bus.gnt_valid_o), 0);
    step(1);
    check("ovf_no_regrant", 32'(bus.gnt_valid_o), 0);
    check("queue_empty", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
